// File: rtl/fir13_da_filter.sv
// fir13_da_filter: 13-tap symmetric low-pass FIR, parallel distributed arithmetic.
// Pipeline: delay line -> pre-add -> DA LUT -> 3-level adder tree -> filter_out.
// Optional macro FIR13_EXTRA_PIPE_EN adds one output register (latency 7 instead of 6).
module fir13_da_filter (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [11:0] filter_in,
  output logic signed [29:0] filter_out
);

  // Half of the symmetric coefficient set, h[0..6]; h[i] = h[12-i].
  localparam logic signed [16:0] H [0:6] = '{
    17'sd259, 17'sd1548, 17'sd5206, 17'sd12097, 17'sd21272, 17'sd29454, 17'sd32768
  };

  logic signed [11:0] dly_q [0:12];
  logic signed [11:0] dly_d [0:12];
  logic signed [12:0] pre_q [0:6];
  logic signed [12:0] pre_d [0:6];
  logic signed [18:0] pp_q  [0:12];
  logic signed [18:0] pp_d  [0:12];
  logic signed [31:0] l1_q  [0:6];
  logic signed [31:0] l1_d  [0:6];
  logic signed [31:0] l2_q  [0:3];
  logic signed [31:0] l2_d  [0:3];
  logic signed [31:0] l3_q  [0:1];
  logic signed [31:0] l3_d  [0:1];
  logic signed [29:0] out_q;
  logic signed [29:0] out_d;
  logic signed [29:0] final_sum;
  logic        [6:0]  lut_addr;
`ifdef FIR13_EXTRA_PIPE_EN
  logic signed [29:0] y_q;
  logic signed [29:0] y_d;
`endif

  // Sum of the coefficients selected by one bit-slice of the pre-added samples.
  function automatic logic signed [18:0] da_lut(input logic [6:0] addr);
    logic signed [18:0] acc;
    acc = '0;
    for (int i = 0; i < 7; i++) begin
      if (addr[i]) acc = acc + {{2{H[i][16]}}, H[i]};
    end
    return acc;
  endfunction

  // Place a partial product at bit weight 2^b; the sign slice carries negative weight.
  function automatic logic signed [31:0] weigh(input logic signed [18:0] pp, input int b);
    logic signed [31:0] ext;
    ext = {{13{pp[18]}}, pp};
    ext = ext <<< b;
    if (b == 12) ext = -ext;
    return ext;
  endfunction

  // Next-state for every pipeline stage.
  always_comb begin
    lut_addr = '0;
    dly_d[0] = filter_in;
    for (int i = 1; i < 13; i++) dly_d[i] = dly_q[i-1];

    for (int i = 0; i < 6; i++)
      pre_d[i] = {dly_q[i][11], dly_q[i]} + {dly_q[12-i][11], dly_q[12-i]};
    pre_d[6] = {dly_q[6][11], dly_q[6]};

    for (int b = 0; b < 13; b++) begin
      for (int i = 0; i < 7; i++) lut_addr[i] = pre_q[i][b];
      pp_d[b] = da_lut(lut_addr);
    end

    for (int j = 0; j < 6; j++)
      l1_d[j] = weigh(pp_q[2*j], 2*j) + weigh(pp_q[2*j+1], 2*j+1);
    l1_d[6] = weigh(pp_q[12], 12);

    for (int j = 0; j < 3; j++) l2_d[j] = l1_q[2*j] + l1_q[2*j+1];
    l2_d[3] = l1_q[6];

    l3_d[0] = l2_q[0] + l2_q[1];
    l3_d[1] = l2_q[2] + l2_q[3];

    // The complete sum is bounded by 2048*172440 < 2^29, so 30 bits hold it exactly.
    final_sum = 30'(l3_q[0] + l3_q[1]);
`ifdef FIR13_EXTRA_PIPE_EN
    y_d   = final_sum;
    out_d = y_q;
`else
    out_d = final_sum;
`endif
  end

  // Pipeline registers, all cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 13; i++) dly_q[i] <= '0;
      for (int i = 0; i < 7; i++)  pre_q[i] <= '0;
      for (int i = 0; i < 13; i++) pp_q[i]  <= '0;
      for (int i = 0; i < 7; i++)  l1_q[i]  <= '0;
      for (int i = 0; i < 4; i++)  l2_q[i]  <= '0;
      for (int i = 0; i < 2; i++)  l3_q[i]  <= '0;
`ifdef FIR13_EXTRA_PIPE_EN
      y_q   <= '0;
`endif
      out_q <= '0;
    end else begin
      for (int i = 0; i < 13; i++) dly_q[i] <= dly_d[i];
      for (int i = 0; i < 7; i++)  pre_q[i] <= pre_d[i];
      for (int i = 0; i < 13; i++) pp_q[i]  <= pp_d[i];
      for (int i = 0; i < 7; i++)  l1_q[i]  <= l1_d[i];
      for (int i = 0; i < 4; i++)  l2_q[i]  <= l2_d[i];
      for (int i = 0; i < 2; i++)  l3_q[i]  <= l3_d[i];
`ifdef FIR13_EXTRA_PIPE_EN
      y_q   <= y_d;
`endif
      out_q <= out_d;
    end
  end

  assign filter_out = out_q;

endmodule

// File: tb/tb_fir13_da_filter.sv
// Scoreboard bench for fir13_da_filter: direct-form MAC reference model,
// expectations queued at stimulus time and popped by an independent monitor.
module tb_fir13_da_filter;

`ifdef FIR13_EXTRA_PIPE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  logic               clk;
  logic               rst;
  logic signed [11:0] filter_in;
  logic signed [29:0] filter_out;

  fir13_da_filter dut (
    .clk        (clk),
    .rst        (rst),
    .filter_in  (filter_in),
    .filter_out (filter_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     h_tab [13] = '{259, 1548, 5206, 12097, 21272, 29454, 32768,
                         29454, 21272, 12097, 5206, 1548, 259};
  int     hist [13];
  longint exp_q [$];
  bit     mon_en = 1'b0;
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: y[k] = sum h[i]*x[k-i], samples before the last reset count as 0.
  task automatic model_push(input int x);
    longint y;
    for (int i = 12; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    y = 0;
    for (int i = 0; i < 13; i++) y += longint'(h_tab[i]) * longint'(hist[i]);
    exp_q.push_back(y);
  endtask

  task automatic drive(input int x);
    @(negedge clk);
    filter_in = 12'(x);
    model_push(x);
  endtask

  // Called shortly after a rising edge with rst already low: outputs for the
  // next LAT edges come from the cleared pipeline.
  task automatic start_stream();
    exp_q.delete();
    for (int i = 0; i < 13; i++) hist[i] = 0;
    for (int i = 0; i < LAT; i++) exp_q.push_back(0);
    mon_en = 1'b1;
  endtask

  // Monitor: one output per cycle, compared against the oldest expectation.
  initial begin
    longint exp;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          check("stream", longint'(filter_out), exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    filter_in = '0;
    #2;
    check("reset_state", longint'(filter_out), 0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    start_stream();

    // Impulse response
    drive(1);
    repeat (20) drive(0);

    // Positive full-scale step
    repeat (25) drive(2047);
    @(posedge clk); #1;
    check("pos_step_settle", longint'(filter_out), 64'sd352984680);

    // Negative full-scale step
    repeat (25) drive(-2048);
    @(posedge clk); #1;
    check("neg_step_settle", longint'(filter_out), -64'sd353157120);

    // Alternating extremes
    for (int i = 0; i < 60; i++) drive((i % 2) ? -2048 : 2047);

    // Random regression
    for (int i = 0; i < 10000; i++) drive(int'($urandom_range(0, 4095)) - 2048);

    // Reset mid-stream, asserted between edges
    repeat (30) drive(int'($urandom_range(0, 4095)) - 2048);
    @(negedge clk);
    #2;
    rst = 1'b1;
    mon_en = 1'b0;
    #1;
    check("async_reset_out", longint'(filter_out), 0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    start_stream();
    drive(1);
    repeat (20) drive(0);

    // Random tail with reset-free operation
    for (int i = 0; i < 200; i++) drive(int'($urandom_range(0, 4095)) - 2048);

    // Drain the queued expectations without adding new ones
    repeat (LAT) begin
      @(negedge clk);
      filter_in = '0;
    end
    @(negedge clk);
    mon_en = 1'b0;
    check("scoreboard_drained", longint'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
